mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 128x16 instruction/data RAM between the processor's instruction-fetch port and a loader/data port. Requests are accepted one at a time, sequenced through a fixed three-state access cycle, and returned with a one-cycle acknowledge carrying the read data. It sits between `mproc`/loader and the RAM inside the processor-plus-memory top level, replacing the direct fetch-to-RAM connection.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Included by the arbiter, its round-robin picker and the bench.
package mem_arb_pkg;

  localparam int unsigned AW_DEFAULT = 7;
  localparam int unsigned DW_DEFAULT = 16;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StAck   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 16
);

  // Fetch port
  logic          req0;
  logic [AW-1:0] addr0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  // Loader/data port
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  // RAM side and status
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          owner;

  modport slave (
    input  req0, addr0, req1, we1, addr1, wdata1, lock1, ram_dout,
    output ack0, rdata0, ack1, rdata1, ram_wr, ram_addr, ram_din, busy, owner
  );

  modport master (
    output req0, addr0, req1, we1, addr1, wdata1, lock1, ram_dout,
    input  ack0, rdata0, ack1, rdata1, ram_wr, ram_addr, ram_din, busy, owner
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker with a priority lock for port 1.
// A tie goes to the port that did not win last time unless lock1 is high.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic lock1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = PORT_FETCH;
    if (req0 && req1) begin
      if (lock1) begin
        winner = PORT_LOAD;
      end else begin
        winner = (last_owner == PORT_FETCH) ? PORT_LOAD : PORT_FETCH;
      end
    end else if (req1) begin
      // lock1 only matters in a tie, so a lone lock1 never reaches here as priority
      winner = PORT_LOAD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the fetch port and the loader port.
// Each access runs IDLE -> GRANT -> ACK; the winner's request is captured on leaving IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  arb_state_e    state_q, state_d;
  logic          owner_q;
  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic pick_valid;
  logic pick_winner;

  logic ack0;
  logic ack1;
  logic ram_wr;
  logic busy;

  rr_pick2 u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .lock1      (bus.lock1),
    .last_owner (owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StGrant;
      StGrant: state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; reset forces StIdle so an in-flight write drops immediately
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    ram_wr = 1'b0;
    busy   = 1'b1;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StGrant: ram_wr = we_q;
      StAck: begin
        ack0 = (owner_q == PORT_FETCH);
        ack1 = (owner_q == PORT_LOAD);
      end
      default: busy = 1'b0;
    endcase
  end

  // Request capture and read-data return
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= PORT_LOAD;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state_q == StIdle && pick_valid) begin
        owner_q <= pick_winner;
        if (pick_winner == PORT_LOAD) begin
          addr_q  <= bus.addr1;
          we_q    <= bus.we1;
          wdata_q <= bus.wdata1;
        end else begin
          // Fetch is read-only; write data stays as last captured
          addr_q <= bus.addr0;
          we_q   <= 1'b0;
        end
      end
      if (state_q == StGrant) begin
        if (owner_q == PORT_FETCH) begin
          rdata0_q <= bus.ram_dout;
        end else if (!we_q) begin
          rdata1_q <= bus.ram_dout;
        end
      end
    end
  end

  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.ram_wr   = ram_wr;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = wdata_q;
  assign bus.busy     = busy;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, an ack monitor popping
// expected results, and directed scenarios for arbitration, latency and reset abort.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic load;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      0:       return 16'o000100;
      1:       return 16'o001201;
      2:       return 16'o002321;
      3:       return 16'o003432;
      default: return 16'(i * 257) ^ 16'h5A00;
    endcase
  endfunction

  // RAM: combinational read, write on the clock edge
  logic [DW-1:0] mem [128];
  assign bus.ram_dout = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
    end else if (bus.ram_wr) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_count = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  always @(negedge clk) begin
    if (bus.ram_wr) begin
      wr_count = wr_count + 1;
      wr_addr  = bus.ram_addr;
      wr_din   = bus.ram_din;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] exp_rd1;

  task automatic push(input logic port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    exp_t e;
    e.port = port;
    if (port == PORT_LOAD) begin
      if (we) ref_mem[addr] = wdata;
      else    exp_rd1 = ref_mem[addr];
      e.data = exp_rd1;
    end else begin
      e.data = ref_mem[addr];
    end
    sb.push_back(e);
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (!reset && (bus.ack0 || bus.ack1)) begin
      check("ack_both", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", 32'(bus.ack1), 32'(e.port));
        check("rdata", 32'(bus.ack1 ? bus.rdata1 : bus.rdata0), 32'(e.data));
      end
    end
  end

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ack0 || bus.ack1) && n < 12);
    if (!(bus.ack0 || bus.ack1)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.addr0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.lock1 = 1'b0;
  endtask

  // Single access from one port; called just after a rising edge
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input string tag);
    int c;
    push(port, we, addr, wdata);
    if (port == PORT_LOAD) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.addr0 = addr;
    end
    c = cyc;
    wait_ack(tag);
    check({tag, "_latency"}, 32'(cyc - c), 32'd2);
    @(posedge clk);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.we1  = 1'b0;
  endtask

  initial begin
    int base;
    int last;
    int c;

    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    exp_rd1 = '0;
    drive_idle();
    reset = 1'b1;
    load  = 1'b1;
    repeat (3) @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_rdata0", 32'(bus.rdata0), 32'd0);
    check("rst_rdata1", 32'(bus.rdata1), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_din", 32'(bus.ram_din), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fetch-only read of word 0
    base = wr_count;
    do_access(PORT_FETCH, 1'b0, 7'h00, 16'h0000, "fetch_rd0");
    check("fetch_no_wr", 32'(wr_count - base), 32'd0);

    // Loader write then read back
    base = wr_count;
    do_access(PORT_LOAD, 1'b1, 7'h05, 16'hBEEF, "load_wr");
    check("wr_pulses", 32'(wr_count - base), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'h05);
    check("wr_din", 32'(wr_din), 32'hBEEF);
    do_access(PORT_LOAD, 1'b0, 7'h05, 16'h0000, "load_rd");

    // Both continuous, round robin
    for (int k = 0; k < 2; k++) begin
      push(PORT_FETCH, 1'b0, 7'h01, 16'h0000);
      push(PORT_LOAD, 1'b0, 7'h02, 16'h0000);
    end
    bus.req0 = 1'b1; bus.addr0 = 7'h01;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 7'h02;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr");
      if (k > 0) check("rr_interval", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(posedge clk);
    #1 drive_idle();

    // Both continuous with lock1: port 1 four times, then port 0 once lock drops
    for (int k = 0; k < 4; k++) push(PORT_LOAD, 1'b0, 7'h02, 16'h0000);
    push(PORT_FETCH, 1'b0, 7'h01, 16'h0000);
    bus.req0 = 1'b1; bus.addr0 = 7'h01;
    bus.req1 = 1'b1; bus.addr1 = 7'h02; bus.lock1 = 1'b1;
    for (int k = 0; k < 4; k++) wait_ack("lock");
    @(posedge clk);
    #1 bus.lock1 = 1'b0;
    wait_ack("unlock");
    @(posedge clk);
    #1 drive_idle();

    // lock1 without req1 has no effect
    bus.lock1 = 1'b1;
    do_access(PORT_FETCH, 1'b0, 7'h03, 16'h0000, "lock_noreq");
    bus.lock1 = 1'b0;

    // Reset during GRANT of a port-1 write
    base = wr_count;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 7'h03; bus.wdata1 = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    check("abort_grant_wr", 32'(bus.ram_wr), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_owner", 32'(bus.owner), 32'd1);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    reset = 1'b0;
    exp_rd1 = '0;
    repeat (5) @(negedge clk);
    check("abort_mem3", 32'(mem[3]), 32'(ref_mem[3]));
    @(posedge clk);
    #1;

    // Port 1 request raised during port 0's ACK waits for the next IDLE
    push(PORT_FETCH, 1'b0, 7'h04, 16'h0000);
    push(PORT_LOAD, 1'b0, 7'h06, 16'h0000);
    bus.req0 = 1'b1; bus.addr0 = 7'h04;
    wait_ack("late_p0");
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 7'h06;
    @(posedge clk);
    #1 bus.req0 = 1'b0;
    c = cyc;
    @(negedge clk);
    check("late_idle_busy", 32'(bus.busy), 32'd0);
    wait_ack("late_p1");
    check("late_latency", 32'(cyc - c), 32'd2);
    @(posedge clk);
    #1 drive_idle();
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
